// File: rtl/acc_responder_if.sv
// Request/response bus of the accumulator responder: one request channel (q) and one
// response channel (p), each with a valid/ready handshake.
interface acc_responder_if #(
  parameter int DataWidth = 32,
  parameter int IdWidth   = 6
);
  logic                 q_valid_i;
  logic                 q_ready_o;
  logic [DataWidth-1:0] q_data_arga_i;
  logic [DataWidth-1:0] q_data_argb_i;
  logic [DataWidth-1:0] q_data_argc_i;
  logic [31:0]          q_data_op_i;
  logic [IdWidth-1:0]   q_id_i;
  logic                 p_valid_o;
  logic                 p_ready_i;
  logic [DataWidth-1:0] p_data_o;
  logic                 p_error_o;
  logic [IdWidth-1:0]   p_id_o;

  modport master (
    output q_valid_i, q_data_arga_i, q_data_argb_i, q_data_argc_i, q_data_op_i, q_id_i,
    input  q_ready_o,
    input  p_valid_o, p_data_o, p_error_o, p_id_o,
    output p_ready_i
  );

  modport slave (
    input  q_valid_i, q_data_arga_i, q_data_argb_i, q_data_argc_i, q_data_op_i, q_id_i,
    output q_ready_o,
    output p_valid_o, p_data_o, p_error_o, p_id_o,
    input  p_ready_i
  );
endinterface

// File: rtl/acc_responder.sv
// Request FIFO feeding a single-issue ALU (ADD/SUB/MAC/AND/XOR) with a held response
// register; responses leave strictly in acceptance order.
module acc_responder #(
  parameter int DataWidth = 32,
  parameter int IdWidth   = 6,
  parameter int ReqDepth  = 2,
  parameter int MulCycles = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  acc_responder_if.slave bus,
  output logic          busy_o
);

  localparam int PtrW = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
  localparam int CntW = $clog2(ReqDepth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(ReqDepth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(ReqDepth);
  localparam logic [2:0]      MacLoad = 3'(MulCycles - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MAC = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  typedef struct packed {
    logic [DataWidth-1:0] a;
    logic [DataWidth-1:0] b;
    logic [DataWidth-1:0] c;
    logic [2:0]           op;
    logic [IdWidth-1:0]   id;
  } req_t;

  // Result is {error, data}; all arithmetic wraps modulo 2^DataWidth.
  function automatic logic [DataWidth:0] alu_eval(input logic [2:0] op,
                                                  input logic [DataWidth-1:0] a,
                                                  input logic [DataWidth-1:0] b,
                                                  input logic [DataWidth-1:0] c);
    logic [DataWidth-1:0] r;
    logic                 e;
    r = '0;
    e = 1'b0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_MAC:  r = a * b + c;
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      default: e = 1'b1;
    endcase
    return {e, r};
  endfunction

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : PtrW'(p + 1'b1);
  endfunction

  req_t                 fifo_mem [ReqDepth];
  logic [PtrW-1:0]      wr_ptr, rd_ptr;
  logic [CntW-1:0]      fifo_cnt;
  logic                 fifo_full, fifo_empty, push, pop;
  req_t                 req_in, head;

  logic [1:0]           state;
  logic [2:0]           cnt;
  logic [DataWidth-1:0] a_p1, b_p1, c_p1;
  logic [2:0]           op_p1;
  logic [IdWidth-1:0]   id_p1;
  logic [DataWidth:0]   res_p1;

  logic [DataWidth-1:0] data_p2;
  logic                 error_p2;
  logic [IdWidth-1:0]   id_p2;
  logic                 vld_p2;

  logic                 unused_op_hi;
  assign unused_op_hi = ^bus.q_data_op_i[31:3];

  assign fifo_full  = (fifo_cnt == FullCnt);
  assign fifo_empty = (fifo_cnt == '0);
  assign push       = bus.q_valid_i && !fifo_full;
  assign pop        = (state == IDLE) && !fifo_empty;
  assign head       = fifo_mem[rd_ptr];

  assign req_in = '{a:  bus.q_data_arga_i, b: bus.q_data_argb_i, c: bus.q_data_argc_i,
                    op: bus.q_data_op_i[2:0], id: bus.q_id_i};

  // ---- FIFO storage (write side, p0)
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= req_in;
  end

  // ---- Exec operand latch (p1)
  always_ff @(posedge clk_i) begin
    if (pop) begin
      a_p1  <= head.a;
      b_p1  <= head.b;
      c_p1  <= head.c;
      op_p1 <= head.op;
      id_p1 <= head.id;
    end
  end

  assign res_p1 = alu_eval(op_p1, a_p1, b_p1, c_p1);

  // ---- Control: FIFO pointers, FSM, response register (p2)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      state    <= IDLE;
      cnt      <= '0;
      data_p2  <= '0;
      error_p2 <= 1'b0;
      id_p2    <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase

      case (state)
        IDLE: begin
          if (pop) begin
            state <= EXEC;
            cnt   <= (head.op == OP_MAC) ? MacLoad : 3'd0;
          end
        end
        EXEC: begin
          if (cnt == 3'd0) begin
            data_p2  <= res_p1[DataWidth-1:0];
            error_p2 <= res_p1[DataWidth];
            id_p2    <= id_p1;
            state    <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.p_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign vld_p2        = (state == RESP);
  assign bus.q_ready_o = !fifo_full;
  assign bus.p_valid_o = vld_p2;
  assign bus.p_data_o  = data_p2;
  assign bus.p_error_o = error_p2;
  assign bus.p_id_o    = id_p2;
  assign busy_o        = !fifo_empty || (state != IDLE);

endmodule

// File: tb/tb_acc_responder.sv
// Directed bench for acc_responder: latency, op results, back-pressure ordering and
// mid-operation reset.
module tb_acc_responder;
  logic clk = 1'b0;
  logic rst_i;
  logic busy_o;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  acc_responder_if #(.DataWidth(32), .IdWidth(6)) ifc ();

  acc_responder #(.DataWidth(32), .IdWidth(6), .ReqDepth(2), .MulCycles(3)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (ifc.slave),
    .busy_o(busy_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [5:0] id);
    ifc.q_valid_i     = 1'b1;
    ifc.q_data_op_i   = op;
    ifc.q_data_arga_i = a;
    ifc.q_data_argb_i = b;
    ifc.q_data_argc_i = c;
    ifc.q_id_i        = id;
  endtask

  task automatic wait_valid(input int bound, input string tag);
    int n;
    n = 0;
    while (ifc.p_valid_o !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    chk({tag, "_arrive"}, ifc.p_valid_o, 1'b1);
  endtask

  // One request on an idle DUT with p_ready held high; lat is edges from acceptance.
  task automatic run_op(input string tag, input logic [31:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c, input logic [5:0] id,
                        input logic [31:0] exp_d, input logic exp_e, input int lat);
    set_req(op, a, b, c, id);
    ifc.p_ready_i = 1'b1;
    chk({tag, "_qrdy"}, ifc.q_ready_o, 1'b1);
    step();
    ifc.q_valid_i = 1'b0;
    for (int k = 1; k < lat; k++) begin
      chk({tag, "_early"}, ifc.p_valid_o, 1'b0);
      step();
    end
    chk({tag, "_valid"}, ifc.p_valid_o, 1'b1);
    chk({tag, "_data"},  ifc.p_data_o,  exp_d);
    chk({tag, "_err"},   ifc.p_error_o, exp_e);
    chk({tag, "_id"},    ifc.p_id_o,    id);
    step();
    chk({tag, "_done"},  ifc.p_valid_o, 1'b0);
  endtask

  initial begin
    logic seen;
    rst_i             = 1'b1;
    ifc.q_valid_i     = 1'b0;
    ifc.q_data_arga_i = '0;
    ifc.q_data_argb_i = '0;
    ifc.q_data_argc_i = '0;
    ifc.q_data_op_i   = '0;
    ifc.q_id_i        = '0;
    ifc.p_ready_i     = 1'b0;
    step();
    step();
    rst_i = 1'b0;

    chk("rst_pvalid", ifc.p_valid_o, 1'b0);
    chk("rst_qready", ifc.q_ready_o, 1'b1);
    chk("rst_busy",   busy_o,        1'b0);
    chk("rst_pdata",  ifc.p_data_o,  32'h0);
    chk("rst_perr",   ifc.p_error_o, 1'b0);
    chk("rst_pid",    ifc.p_id_o,    6'h0);

    run_op("add",     32'd0, 32'd5, 32'd7, 32'd0, 6'h21, 32'd12, 1'b0, 3);
    run_op("mac",     32'd2, 32'd3, 32'd4, 32'd5, 6'h0A, 32'd17, 1'b0, 5);
    run_op("sub",     32'd1, 32'd0, 32'd1, 32'd0, 6'h02, 32'hFFFF_FFFF, 1'b0, 3);
    run_op("and",     32'd3, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 6'h03, 32'h00F0_1200, 1'b0, 3);
    run_op("xor",     32'd4, 32'hAAAA_5555, 32'hFFFF_0000, 32'd0, 6'h04, 32'h5555_5555, 1'b0, 3);
    run_op("illegal", 32'd6, 32'd9, 32'd9, 32'd9, 6'h05, 32'd0, 1'b1, 3);
    run_op("ill7",    32'd7, 32'd1, 32'd2, 32'd3, 6'h3F, 32'd0, 1'b1, 3);
    run_op("macwrap", 32'd2, 32'hFFFF_FFFF, 32'd2, 32'd3, 6'h11, 32'h0000_0001, 1'b0, 5);
    run_op("opupper", 32'hFFFF_FFF8, 32'd100, 32'd23, 32'd0, 6'h22, 32'd123, 1'b0, 3);
    chk("idle_busy", busy_o, 1'b0);

    // Back-pressure: first request parks in RESP, two more fill the FIFO.
    ifc.p_ready_i = 1'b0;
    set_req(32'd0, 32'd1, 32'd1, 32'd0, 6'h11);
    step();
    set_req(32'd1, 32'd10, 32'd3, 32'd0, 6'h12);
    step();
    set_req(32'd4, 32'hF0, 32'hFF, 32'd0, 6'h13);
    step();
    chk("bp_full", ifc.q_ready_o, 1'b0);
    set_req(32'd3, 32'hFF, 32'h0F, 32'd0, 6'h14);
    step();
    chk("bp_still_full", ifc.q_ready_o, 1'b0);
    chk("bp_busy",       busy_o,        1'b1);
    ifc.q_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_valid", ifc.p_valid_o, 1'b1);
      chk("bp_hold_data",  ifc.p_data_o,  32'd2);
      chk("bp_hold_id",    ifc.p_id_o,    6'h11);
      step();
    end
    ifc.p_ready_i = 1'b1;
    wait_valid(20, "bp_r1");
    chk("bp_r1_id",   ifc.p_id_o,   6'h11);
    chk("bp_r1_data", ifc.p_data_o, 32'd2);
    step();
    wait_valid(20, "bp_r2");
    chk("bp_r2_id",   ifc.p_id_o,   6'h12);
    chk("bp_r2_data", ifc.p_data_o, 32'd7);
    step();
    wait_valid(20, "bp_r3");
    chk("bp_r3_id",   ifc.p_id_o,   6'h13);
    chk("bp_r3_data", ifc.p_data_o, 32'h0F);
    step();
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (ifc.p_valid_o === 1'b1) seen = 1'b1;
      step();
    end
    chk("bp_no_extra", seen,   1'b0);
    chk("bp_drained",  busy_o, 1'b0);

    // Reset while a MAC is in EXEC with two requests queued behind it.
    ifc.p_ready_i = 1'b0;
    set_req(32'd2, 32'd6, 32'd7, 32'd1, 6'h31);
    step();
    set_req(32'd0, 32'd1, 32'd2, 32'd0, 6'h32);
    step();
    set_req(32'd0, 32'd3, 32'd4, 32'd0, 6'h33);
    step();
    ifc.q_valid_i = 1'b0;
    chk("mr_busy_before",  busy_o,        1'b1);
    chk("mr_full_before",  ifc.q_ready_o, 1'b0);
    chk("mr_exec_novalid", ifc.p_valid_o, 1'b0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("mr_pvalid", ifc.p_valid_o, 1'b0);
    chk("mr_qready", ifc.q_ready_o, 1'b1);
    chk("mr_busy",   busy_o,        1'b0);
    chk("mr_pid",    ifc.p_id_o,    6'h0);
    ifc.p_ready_i = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (ifc.p_valid_o === 1'b1) seen = 1'b1;
      step();
    end
    chk("mr_no_stale", seen, 1'b0);

    run_op("post_rst", 32'd0, 32'd40, 32'd2, 32'd0, 6'h2A, 32'd42, 1'b0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
